// File: rtl/nor_seq_pkg.sv
// Shared definitions for the bit-serial NOR-based XNOR sequencer.
package nor_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        S_NA   = 3'd1,
        S_NB   = 3'd2,
        S_AND1 = 3'd3,
        S_AND2 = 3'd4,
        S_OR   = 3'd5,
        S_OUT  = 3'd6,
        DONE   = 3'd7
    } state_t;

    localparam int unsigned NOR_STEPS = 6;

    // Bit-index width; a one-bit operand still needs a 1-bit index register.
    function automatic int unsigned idx_w(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/nor_unit.sv
// Single shared 2-input NOR resource.
module nor_unit (
    output logic s,
    input  logic x,
    input  logic y
);

    nor u_nor (s, x, y);

endmodule

// File: rtl/nor_xnor_seq.sv
// Bit-serial XNOR engine: sequences six evaluations of one shared NOR gate per bit.
module nor_xnor_seq
    import nor_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned OPS_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [OPS_W-1:0] nor_ops
);

    localparam int unsigned IW = idx_w(WIDTH);

    state_t           r_state;
    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_result;
    logic             r_na;
    logic             r_nb;
    logic             r_and1;
    logic             r_and2;
    logic             r_orv;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;
    logic [OPS_W-1:0] r_nor_ops;

    logic w_x;
    logic w_y;
    logic w_in0;
    logic w_in1;
    logic w_nor;

    assign w_x = r_opa[r_idx];
    assign w_y = r_opb[r_idx];

    always_comb begin
        w_in0 = 1'b0;
        w_in1 = 1'b0;
        case (r_state)
            S_NA:    begin w_in0 = w_x;    w_in1 = w_x;    end
            S_NB:    begin w_in0 = w_y;    w_in1 = w_y;    end
            S_AND1:  begin w_in0 = r_na;   w_in1 = r_nb;   end
            S_AND2:  begin w_in0 = w_x;    w_in1 = w_y;    end
            S_OR:    begin w_in0 = r_and1; w_in1 = r_and2; end
            S_OUT:   begin w_in0 = r_orv;  w_in1 = r_orv;  end
            default: begin w_in0 = 1'b0;   w_in1 = 1'b0;   end
        endcase
    end

    nor_unit u_nor_unit (
        .s (w_nor),
        .x (w_in0),
        .y (w_in1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_result <= '0;
            r_na     <= 1'b0;
            r_nb     <= 1'b0;
            r_and1   <= 1'b0;
            r_and2   <= 1'b0;
            r_orv    <= 1'b0;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_opa    <= a;
                        r_opb    <= b;
                        r_result <= '0;
                        r_idx    <= '0;
                        r_state  <= S_NA;
                        r_ready  <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end
                S_NA:   begin r_na   <= w_nor; r_state <= S_NB;   end
                S_NB:   begin r_nb   <= w_nor; r_state <= S_AND1; end
                S_AND1: begin r_and1 <= w_nor; r_state <= S_AND2; end
                S_AND2: begin r_and2 <= w_nor; r_state <= S_OR;   end
                S_OR:   begin r_orv  <= w_nor; r_state <= S_OUT;  end
                S_OUT: begin
                    r_result[r_idx] <= w_nor;
                    if (r_idx == IW'(WIDTH - 1)) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_state <= S_NA;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // r_busy is high exactly in the micro-step states, i.e. on every NOR evaluation edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nor_ops <= '0;
        end else if (r_busy && (r_nor_ops != '1)) begin
            r_nor_ops <= r_nor_ops + 1'b1;
        end
    end

    assign ready   = r_ready;
    assign busy    = r_busy;
    assign done    = r_done;
    assign result  = r_result;
    assign nor_ops = r_nor_ops;

endmodule

// File: tb/tb_nor_xnor_seq.sv
// Directed scoreboard bench for nor_xnor_seq (WIDTH=8, OPS_W=8 to reach saturation).
module tb_nor_xnor_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       ready;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic [7:0] nor_ops;

    int unsigned total;
    int unsigned bad;
    int unsigned done_cnt;
    logic [7:0]  sb_q[$];

    nor_xnor_seq #(.WIDTH(8), .OPS_W(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .nor_ops (nor_ops)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt = done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v,
                          input bit inject, input int unsigned exp_ops);
        int unsigned n;
        int unsigned d0;
        logic [7:0]  exp_res;
        bit          seen;
        @(negedge clk);
        a = ta;
        b = tb_v;
        start = 1'b1;
        @(posedge clk);
        sb_q.push_back(~(ta ^ tb_v));
        d0 = done_cnt;
        #1;
        start = 1'b0;
        check("busy_after_accept", {31'b0, busy}, 32'd1);
        seen = 1'b0;
        n = 0;
        for (int unsigned k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            n = k;
            if (inject && k == 10) begin
                a = 8'h0F;
                b = 8'hF0;
                start = 1'b1;
            end
            if (inject && k == 11) start = 1'b0;
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", {31'b0, seen}, 32'd1);
        if (seen) begin
            exp_res = sb_q.pop_front();
            check("latency", n, 32'd48);
            check("result", {24'b0, result}, {24'b0, exp_res});
            check("nor_ops", {24'b0, nor_ops}, exp_ops);
            check("ready_in_done", {31'b0, ready}, 32'd0);
            @(posedge clk);
            #1;
            check("done_one_cycle", {31'b0, done}, 32'd0);
            check("ready_after_done", {31'b0, ready}, 32'd1);
            check("done_count", done_cnt - d0, 32'd1);
        end else begin
            void'(sb_q.pop_front());
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        done_cnt = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_ready", {31'b0, ready}, 32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_result", {24'b0, result}, 32'h00);
        check("rst_nor_ops", {24'b0, nor_ops}, 32'd0);

        run_op(8'hA5, 8'h3C, 1'b0, 48);
        check("basic_66", {24'b0, result}, 32'h66);
        run_op(8'hFF, 8'hFF, 1'b0, 96);
        check("ff_ff", {24'b0, result}, 32'hFF);
        run_op(8'h00, 8'hFF, 1'b0, 144);
        check("00_ff", {24'b0, result}, 32'h00);
        run_op(8'h00, 8'h00, 1'b0, 192);
        check("00_00", {24'b0, result}, 32'hFF);

        run_op(8'hA5, 8'h3C, 1'b1, 240);
        check("busy_start_ignored", {24'b0, result}, 32'h66);
        repeat (3) @(posedge clk);
        #1;
        check("no_late_accept", {31'b0, busy}, 32'd0);

        // Reset 20 cycles into an operation.
        @(negedge clk);
        a = 8'h12;
        b = 8'h34;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        begin
            int unsigned d0;
            d0 = done_cnt;
            repeat (20) @(posedge clk);
            #1;
            rst_n = 1'b0;
            #1;
            check("midrst_result", {24'b0, result}, 32'h00);
            check("midrst_busy", {31'b0, busy}, 32'd0);
            check("midrst_nor_ops", {24'b0, nor_ops}, 32'd0);
            repeat (2) @(posedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            repeat (60) @(posedge clk);
            #1;
            check("midrst_no_done", done_cnt - d0, 32'd0);
            check("midrst_ready", {31'b0, ready}, 32'd1);
            check("midrst_result_hold", {24'b0, result}, 32'h00);
        end

        for (int unsigned k = 1; k <= 6; k++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom);
            rb = 8'($urandom);
            run_op(ra, rb, 1'b0, (48 * k > 255) ? 255 : 48 * k);
        end
        repeat (3) @(posedge clk);
        #1;
        check("sat_hold", {24'b0, nor_ops}, 32'd255);
        check("sb_empty", sb_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
